// File: rtl/encoder16_seq_if.sv
// ---------------------------------------------------------------------------
// encoder16_seq_if
// Handshake bundle for encoder16_seq.
//   in_valid / in_ready / in_y           : 16-line vector input stream
//   out_valid / out_ready / out_a        : binary index output stream
//   out_last / out_zero / onehot_err     : per-beat side information
// Modports:
//   slave  : the encoder (consumes vectors, produces indices)
//   master : the environment (produces vectors, consumes indices)
// ---------------------------------------------------------------------------
interface encoder16_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_a;
  logic        out_last;
  logic        out_zero;
  logic        onehot_err;

  modport slave (
    input  in_valid, in_y, out_ready,
    output in_ready, out_valid, out_a, out_last, out_zero, onehot_err
  );

  modport master (
    output in_valid, in_y, out_ready,
    input  in_ready, out_valid, out_a, out_last, out_zero, onehot_err
  );
endinterface

// File: rtl/encoder16_seq.sv
// ---------------------------------------------------------------------------
// encoder16_seq
// Sequential 16-to-4 encoder. Captures a 16-bit line vector and emits the
// binary index of every set line, lowest first, one index per output beat.
// An all-zero vector produces a single beat flagged with out_zero.
//
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : encoder16_seq_if.slave
//              in_valid/in_ready/in_y          vector capture handshake
//              out_valid/out_ready/out_a       index stream
//              out_last   final beat of the current vector
//              out_zero   captured vector was all-zero
//              onehot_err captured vector had two or more bits set
//
// Optional feature macro: ENCODER16_ONEHOT_CHECK_EN
//   defined   : onehot_err reports multi-hot vectors for every beat
//   undefined : onehot_err is tied low
//
// All outputs come straight from flops; their next values are derived from
// the next-state values so that beats appear the cycle after capture.
// ---------------------------------------------------------------------------
module encoder16_seq (
  input  logic            clk,
  input  logic            reset_n,
  encoder16_seq_if.slave  bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  // Index of the lowest set bit; 0 for an empty vector.
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // True when at most one bit of v is set.
  function automatic logic at_most_one(input logic [15:0] v);
    return (v & (v - 16'd1)) == 16'd0;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic        zflag_q, zflag_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_a_q, out_a_d;
  logic        out_last_q, out_last_d;
  logic        out_zero_q, out_zero_d;
  logic        emit_d;
`ifdef ENCODER16_ONEHOT_CHECK_EN
  logic        errflag_q, errflag_d;
  logic        onehot_err_q, onehot_err_d;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zflag_d = zflag_q;
`ifdef ENCODER16_ONEHOT_CHECK_EN
    errflag_d = errflag_q;
`endif

    unique case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone captures.
        if (bus.in_valid) begin
          pend_d  = bus.in_y;
          zflag_d = (bus.in_y == 16'd0);
`ifdef ENCODER16_ONEHOT_CHECK_EN
          errflag_d = !at_most_one(bus.in_y);
`endif
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          pend_d = pend_q & (pend_q - 16'd1);
          if (out_last_q) begin
            state_d = IDLE;
            pend_d  = 16'd0;
            zflag_d = 1'b0;
`ifdef ENCODER16_ONEHOT_CHECK_EN
            errflag_d = 1'b0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output flops are loaded from next-state values so they are valid in
    // the cycle right after capture and after each accepted beat.
    emit_d      = (state_d == EMIT);
    in_ready_d  = !emit_d;
    out_valid_d = emit_d;
    out_a_d     = (emit_d && !zflag_d) ? lowest_idx(pend_d) : 4'd0;
    out_last_d  = emit_d && (zflag_d || at_most_one(pend_d));
    out_zero_d  = emit_d && zflag_d;
`ifdef ENCODER16_ONEHOT_CHECK_EN
    onehot_err_d = emit_d && errflag_d;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pend_q      <= 16'd0;
      zflag_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_a_q     <= 4'd0;
      out_last_q  <= 1'b0;
      out_zero_q  <= 1'b0;
`ifdef ENCODER16_ONEHOT_CHECK_EN
      errflag_q    <= 1'b0;
      onehot_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      zflag_q     <= zflag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_last_q  <= out_last_d;
      out_zero_q  <= out_zero_d;
`ifdef ENCODER16_ONEHOT_CHECK_EN
      errflag_q    <= errflag_d;
      onehot_err_q <= onehot_err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_zero  = out_zero_q;
`ifdef ENCODER16_ONEHOT_CHECK_EN
  assign bus.onehot_err = onehot_err_q;
`else
  assign bus.onehot_err = 1'b0;
`endif

endmodule

// File: tb/tb_encoder16_seq.sv
// ---------------------------------------------------------------------------
// tb_encoder16_seq
// Scoreboard bench for encoder16_seq. The driver pushes the expected beat
// list of every captured vector (derived from the set bits of the vector)
// into a queue; a monitor pops and compares on every output handshake and
// also checks latency, hold-while-stalled and in_ready/out_valid exclusion.
// ---------------------------------------------------------------------------
module tb_encoder16_seq;

`ifdef ENCODER16_ONEHOT_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  encoder16_seq_if bus();

  encoder16_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [3:0] a;
    logic       last;
    logic       zero;
    logic       err;
  } beat_t;

  beat_t sbq[$];
  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: one beat per set line in ascending order, or one zero beat.
  function automatic void model_push(input logic [15:0] v);
    int n;
    int hi;
    beat_t b;
    n = $countones(v);
    if (n == 0) begin
      b = '{a: 4'd0, last: 1'b1, zero: 1'b1, err: 1'b0};
      sbq.push_back(b);
    end else begin
      hi = -1;
      for (int i = 0; i < 16; i++) if (v[i]) hi = i;
      for (int i = 0; i < 16; i++) begin
        if (v[i]) begin
          b = '{a: 4'(i), last: (i == hi), zero: 1'b0, err: (ERR_EN && n > 1)};
          sbq.push_back(b);
        end
      end
    end
  endfunction

  // out_ready driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor
  logic  cap_seen = 1'b0;
  logic  last_hs  = 1'b0;
  logic  stall    = 1'b0;
  beat_t st;
  beat_t exp_b;

  always @(negedge clk) begin
    if (!reset_n) begin
      cap_seen = 1'b0;
      last_hs  = 1'b0;
      stall    = 1'b0;
    end else begin
      if (cap_seen) chk("latency_out_valid", bus.out_valid, 1);
      if (last_hs)  chk("in_ready_after_last", bus.in_ready, 1);
      if (stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_a",     bus.out_a,     st.a);
        chk("stall_last",  bus.out_last,  st.last);
        chk("stall_zero",  bus.out_zero,  st.zero);
        chk("stall_err",   bus.onehot_err, st.err);
      end
      chk("ready_excl", bus.in_ready, !bus.out_valid);
      if (!bus.out_valid) chk("idle_err", bus.onehot_err, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          exp_b = sbq.pop_front();
          chk("beat_a",    bus.out_a,      exp_b.a);
          chk("beat_last", bus.out_last,   exp_b.last);
          chk("beat_zero", bus.out_zero,   exp_b.zero);
          chk("beat_err",  bus.onehot_err, exp_b.err);
        end
      end
      cap_seen = bus.in_valid && bus.in_ready;
      last_hs  = bus.out_valid && bus.out_ready && bus.out_last;
      stall    = bus.out_valid && !bus.out_ready;
      st       = '{a: bus.out_a, last: bus.out_last, zero: bus.out_zero, err: bus.onehot_err};
    end
  end

  // Present v and hold it until captured; returns #1 after the capture edge.
  task automatic send(input logic [15:0] v);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_y     = v;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        chk("capture_timeout", 0, 1);
        return;
      end
    end
    model_push(v);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sbq.size() == 0 && !bus.out_valid) break;
      n++;
      if (n > 400) begin
        chk("drain_timeout", 0, 1);
        sbq.delete();
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   bus.in_ready,   1);
    chk({tag, "_out_valid"},  bus.out_valid,  0);
    chk({tag, "_out_a"},      bus.out_a,      0);
    chk({tag, "_out_last"},   bus.out_last,   0);
    chk({tag, "_out_zero"},   bus.out_zero,   0);
    chk({tag, "_onehot_err"}, bus.onehot_err, 0);
  endtask

  initial begin
    logic [15:0] v;
    int kind;
    bus.in_valid = 1'b0;
    bus.in_y     = 16'd0;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    #2 reset_n = 1'b1;
    #1 chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // Decoder loopback
    rdy_mode = 0;
    for (int a = 0; a < 16; a++) send(16'(1 << a));
    bus.in_valid = 1'b0;
    drain();

    // Multi-hot 8421: four consecutive beats
    send(16'h8421);
    bus.in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("mh_valid", bus.out_valid, 1);
      chk("mh_a", bus.out_a, j * 5);
      chk("mh_last", bus.out_last, (j == 3));
      chk("mh_err", bus.onehot_err, ERR_EN);
    end
    drain();

    // Zero vector
    send(16'h0000);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("zero_valid", bus.out_valid, 1);
    chk("zero_flag", bus.out_zero, 1);
    chk("zero_last", bus.out_last, 1);
    chk("zero_a", bus.out_a, 0);
    @(negedge clk);
    chk("zero_in_ready_next", bus.in_ready, 1);
    drain();

    // Back-pressure on a full vector
    rdy_mode = 1;
    send(16'hFFFF);
    bus.in_valid = 1'b0;
    drain();
    rdy_mode = 0;

    // Back-to-back capture with in_valid held high
    send(16'h0003);
    send(16'h0010);
    bus.in_valid = 1'b0;
    drain();

    // Reset in the middle of EMIT discards pending beats
    rdy_mode = 2;
    send(16'hFFFF);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    sbq.delete();
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1 chk("mid_rst_rel_in_ready", bus.in_ready, 1);
    chk("mid_rst_rel_out_valid", bus.out_valid, 0);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Randomized vectors with random back-pressure and input gaps
    for (int it = 0; it < 60; it++) begin
      rdy_mode = $urandom_range(0, 1);
      kind = $urandom_range(0, 3);
      case (kind)
        0:       v = 16'h0000;
        1:       v = 16'(1 << $urandom_range(0, 15));
        2:       v = 16'($urandom & $urandom & $urandom);
        default: v = 16'($urandom);
      endcase
      send(v);
      if ($urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    drain();
    chk("final_queue_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
